alarm_controller: RTL and testbench

Alarm stage directly downstream of the time-keeping counter. Holds a BCD alarm time, compares it against the running HH:MM each cycle and runs the arm/ring/snooze state machine. Drives the buzzer and indicator LED. Exports the alarm time to the display mux while in alarm-adjust mode. All control inputs are single-cycle pulses from the pushbutton detectors.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/bcd_wrap_adjust.sv | 50 +++++
 rtl/alarm_controller.sv | 187 ++++++++++++++++++
 tb/tb_alarm_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the alarm clock: alarm state encoding, BCD field limits
// and digit widths of the HH:MM time fields.
package clock_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } alarm_state_e;

  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  localparam int HR_TENS_W   = 2;
  localparam int HR_UNITS_W  = 4;
  localparam int MIN_TENS_W  = 3;
  localparam int MIN_UNITS_W = 4;

endpackage

// File: rtl/bcd_wrap_adjust.sv
// Combinational up/down step of a two-digit BCD field that wraps between 0 and MAX_VAL.
// Simultaneous up and down cancel; with neither, the field passes through unchanged.
module bcd_wrap_adjust #(
  parameter int MAX_VAL = 59,
  parameter int TENS_W  = 3
) (
  input  logic [TENS_W-1:0] tens_in,
  input  logic [3:0]        units_in,
  input  logic              up,
  input  logic              dn,
  output logic [TENS_W-1:0] tens_out,
  output logic [3:0]        units_out
);

  localparam logic [TENS_W-1:0] MAX_TENS  = TENS_W'(MAX_VAL / 10);
  localparam logic [3:0]        MAX_UNITS = 4'(MAX_VAL % 10);

  logic at_max;
  logic at_zero;

  assign at_max  = (tens_in == MAX_TENS) && (units_in == MAX_UNITS);
  assign at_zero = (tens_in == '0) && (units_in == 4'd0);

  always_comb begin
    tens_out  = tens_in;
    units_out = units_in;
    if (up && !dn) begin
      if (at_max) begin
        tens_out  = '0;
        units_out = 4'd0;
      end else if (units_in == 4'd9) begin
        tens_out  = tens_in + TENS_W'(1);
        units_out = 4'd0;
      end else begin
        units_out = units_in + 4'd1;
      end
    end else if (dn && !up) begin
      if (at_zero) begin
        tens_out  = MAX_TENS;
        units_out = MAX_UNITS;
      end else if (units_in == 4'd0) begin
        tens_out  = tens_in - TENS_W'(1);
        units_out = 4'd9;
      end else begin
        units_out = units_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm stage: stores the BCD alarm time, detects a new match with the running HH:MM
// and runs the arm/ring/snooze FSM. Optional snooze support is built with ALARM_SNOOZE_EN.
module alarm_controller
  import clock_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60
`ifdef ALARM_SNOOZE_EN
  , parameter int SNOOZE_S = 300
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_1hz,
  input  logic [HR_TENS_W-1:0]   cur_hours_tens,
  input  logic [HR_UNITS_W-1:0]  cur_hours,
  input  logic [MIN_TENS_W-1:0]  cur_minutes_tens,
  input  logic [MIN_UNITS_W-1:0] cur_minutes,
  input  logic                   adj_en,
  input  logic                   min_up,
  input  logic                   min_dn,
  input  logic                   hr_up,
  input  logic                   hr_dn,
  input  logic                   arm_toggle,
  input  logic                   stop,
  input  logic                   snooze,
  output logic [HR_TENS_W-1:0]   alarm_hours_tens,
  output logic [HR_UNITS_W-1:0]  alarm_hours,
  output logic [MIN_TENS_W-1:0]  alarm_minutes_tens,
  output logic [MIN_UNITS_W-1:0] alarm_minutes,
  output logic                   armed,
  output logic                   buzzer,
  output logic                   ring_led
);

  localparam int RING_W = $clog2(RING_TIMEOUT_S + 1);

  alarm_state_e state_reg, state_next;

  logic [HR_TENS_W-1:0]   alarm_hr_tens_reg, alarm_hr_tens_next;
  logic [HR_UNITS_W-1:0]  alarm_hr_reg, alarm_hr_next;
  logic [MIN_TENS_W-1:0]  alarm_min_tens_reg, alarm_min_tens_next;
  logic [MIN_UNITS_W-1:0] alarm_min_reg, alarm_min_next;

  logic [RING_W-1:0] ring_cnt_reg;
  logic              led_reg;
  logic              match_q_reg;
  logic              match;
  logic              fire;
  logic              ring_timeout;
  logic              snooze_timeout;

  // Adjust pulses only count while the top FSM is in an alarm-adjust state.
  bcd_wrap_adjust #(.MAX_VAL(MIN_MAX), .TENS_W(MIN_TENS_W)) u_min_adj (
    .tens_in   (alarm_min_tens_reg),
    .units_in  (alarm_min_reg),
    .up        (adj_en & min_up),
    .dn        (adj_en & min_dn),
    .tens_out  (alarm_min_tens_next),
    .units_out (alarm_min_next)
  );

  bcd_wrap_adjust #(.MAX_VAL(HR_MAX), .TENS_W(HR_TENS_W)) u_hr_adj (
    .tens_in   (alarm_hr_tens_reg),
    .units_in  (alarm_hr_reg),
    .up        (adj_en & hr_up),
    .dn        (adj_en & hr_dn),
    .tens_out  (alarm_hr_tens_next),
    .units_out (alarm_hr_next)
  );

  assign match = (cur_hours_tens == alarm_hr_tens_reg) && (cur_hours == alarm_hr_reg) &&
                 (cur_minutes_tens == alarm_min_tens_reg) && (cur_minutes == alarm_min_reg);
  // Only the rising edge of match fires, and never while the alarm is being edited.
  assign fire = match & ~match_q_reg & ~adj_en;

  assign ring_timeout = (state_reg == RINGING) && tick_1hz &&
                        (ring_cnt_reg == RING_W'(RING_TIMEOUT_S - 1));

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_S + 1);
  logic [SNZ_W-1:0] snz_cnt_reg;

  assign snooze_timeout = (state_reg == SNOOZE) && tick_1hz &&
                          (snz_cnt_reg == SNZ_W'(SNOOZE_S - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      snz_cnt_reg <= '0;
    end else if (state_next == SNOOZE && state_reg != SNOOZE) begin
      snz_cnt_reg <= '0;
    end else if (state_reg == SNOOZE && tick_1hz) begin
      snz_cnt_reg <= snz_cnt_reg + SNZ_W'(1);
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze  = snooze;
  assign snooze_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= DISARMED;
      alarm_hr_tens_reg  <= '0;
      alarm_hr_reg       <= '0;
      alarm_min_tens_reg <= '0;
      alarm_min_reg      <= '0;
      match_q_reg        <= 1'b1;
    end else begin
      state_reg          <= state_next;
      alarm_hr_tens_reg  <= alarm_hr_tens_next;
      alarm_hr_reg       <= alarm_hr_next;
      alarm_min_tens_reg <= alarm_min_tens_next;
      alarm_min_reg      <= alarm_min_next;
      match_q_reg        <= match;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ring_cnt_reg <= '0;
      led_reg      <= 1'b0;
    end else if (state_next == RINGING && state_reg != RINGING) begin
      ring_cnt_reg <= '0;
      led_reg      <= 1'b0;
    end else if (state_reg == RINGING && tick_1hz) begin
      ring_cnt_reg <= ring_cnt_reg + RING_W'(1);
      led_reg      <= ~led_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DISARMED: begin
        if (arm_toggle) state_next = ARMED;
      end
      ARMED: begin
        if (arm_toggle) state_next = DISARMED;
        else if (fire)  state_next = RINGING;
      end
      RINGING: begin
        if (arm_toggle)        state_next = DISARMED;
        else if (stop)         state_next = ARMED;
`ifdef ALARM_SNOOZE_EN
        else if (snooze)       state_next = SNOOZE;
`endif
        else if (ring_timeout) state_next = ARMED;
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (arm_toggle)          state_next = DISARMED;
        else if (stop)           state_next = ARMED;
        else if (snooze_timeout) state_next = RINGING;
      end
`endif
      default: state_next = DISARMED;
    endcase
  end

  always_comb begin
    armed    = 1'b0;
    buzzer   = 1'b0;
    ring_led = 1'b0;
    case (state_reg)
      ARMED: armed = 1'b1;
      RINGING: begin
        armed    = 1'b1;
        buzzer   = 1'b1;
        ring_led = led_reg;
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        armed    = 1'b1;
        ring_led = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign alarm_hours_tens   = alarm_hr_tens_reg;
  assign alarm_hours        = alarm_hr_reg;
  assign alarm_minutes_tens = alarm_min_tens_reg;
  assign alarm_minutes      = alarm_min_reg;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: stimulus queues expected outputs, a negedge
// monitor pops and compares them against the sampled DUT outputs.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [1:0] cur_hours_tens;
  logic [3:0] cur_hours;
  logic [2:0] cur_minutes_tens;
  logic [3:0] cur_minutes;
  logic       adj_en, min_up, min_dn, hr_up, hr_dn, arm_toggle, stop, snooze;
  logic [1:0] alarm_hours_tens;
  logic [3:0] alarm_hours;
  logic [2:0] alarm_minutes_tens;
  logic [3:0] alarm_minutes;
  logic       armed, buzzer, ring_led;

  always #5 clk = ~clk;

  alarm_controller dut (
    .clk                (clk),
    .reset              (reset),
    .tick_1hz           (tick_1hz),
    .cur_hours_tens     (cur_hours_tens),
    .cur_hours          (cur_hours),
    .cur_minutes_tens   (cur_minutes_tens),
    .cur_minutes        (cur_minutes),
    .adj_en             (adj_en),
    .min_up             (min_up),
    .min_dn             (min_dn),
    .hr_up              (hr_up),
    .hr_dn              (hr_dn),
    .arm_toggle         (arm_toggle),
    .stop               (stop),
    .snooze             (snooze),
    .alarm_hours_tens   (alarm_hours_tens),
    .alarm_hours        (alarm_hours),
    .alarm_minutes_tens (alarm_minutes_tens),
    .alarm_minutes      (alarm_minutes),
    .armed              (armed),
    .buzzer             (buzzer),
    .ring_led           (ring_led)
  );

  typedef struct {
    string       name;
    logic [15:0] exp;
    logic [15:0] mask;
  } chk_t;

  chk_t sb_q[$];
  chk_t mon_c;
  int   total = 0;
  int   bad   = 0;

  localparam logic [15:0] M_FLAGS = 16'hE000;
  localparam logic [15:0] M_TIME  = 16'h1FFF;

  localparam logic [6:0] MINU = 7'h40, MIND = 7'h20, HRU = 7'h10, HRD = 7'h08;
  localparam logic [6:0] ARM  = 7'h04, STP  = 7'h02, SNZ = 7'h01;

  wire [15:0] obs = {armed, buzzer, ring_led, alarm_hours_tens, alarm_hours,
                     alarm_minutes_tens, alarm_minutes};

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_c = sb_q.pop_front();
      total++;
      if ((obs & mon_c.mask) !== (mon_c.exp & mon_c.mask)) begin
        bad++;
        $display("FAIL %s: got %h want %h", mon_c.name, obs & mon_c.mask,
                 mon_c.exp & mon_c.mask);
      end else begin
        $display("ok   %s: %h", mon_c.name, obs & mon_c.mask);
      end
    end
  end

  task automatic exp_flags(input string n, input logic a, input logic b, input logic l);
    sb_q.push_back('{n, {a, b, l, 13'd0}, M_FLAGS});
  endtask

  task automatic exp_time(input string n, input int ht, input int hu, input int mt, input int mu);
    sb_q.push_back('{n, {3'd0, 2'(ht), 4'(hu), 3'(mt), 4'(mu)}, M_TIME});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int ht, input int hu, input int mt, input int mu);
    cur_hours_tens   = 2'(ht);
    cur_hours        = 4'(hu);
    cur_minutes_tens = 3'(mt);
    cur_minutes      = 4'(mu);
  endtask

  task automatic pulse(input logic [6:0] w);
    {min_up, min_dn, hr_up, hr_dn, arm_toggle, stop, snooze} = w;
    step();
    {min_up, min_dn, hr_up, hr_dn, arm_toggle, stop, snooze} = 7'd0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      step();
    end
  endtask

  task automatic ring_again();
    set_time(0, 7, 3, 1);
    step();
    set_time(0, 7, 3, 0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    tick_1hz = 1'b0;
    adj_en = 1'b0;
    {min_up, min_dn, hr_up, hr_dn, arm_toggle, stop, snooze} = 7'd0;
    set_time(0, 0, 0, 0);
    step();
    step();
    exp_flags("reset_flags", 0, 0, 0);
    exp_time("reset_time", 0, 0, 0, 0);
    reset = 1'b0;
    step();
    exp_flags("no_fire_after_reset", 0, 0, 0);

    // 1: arm, set alarm 07:30, step current time across it
    pulse(ARM);
    exp_flags("armed", 1, 0, 0);
    set_time(0, 7, 2, 9);
    adj_en = 1'b1;
    for (int i = 0; i < 7; i++) pulse(HRU | MINU);
    for (int i = 0; i < 23; i++) pulse(MINU);
    adj_en = 1'b0;
    exp_time("alarm_0730", 0, 7, 3, 0);
    step();
    set_time(0, 7, 3, 0);
    exp_flags("pre_fire", 1, 0, 0);
    step();
    exp_flags("fire_one_clk", 1, 1, 0);

    // 2: ring timeout, no re-fire on hold, re-fire on new match
    ticks(59);
    exp_flags("ring_59_ticks", 1, 1, 1);
    ticks(1);
    exp_flags("ring_timeout", 1, 0, 0);
    repeat (5) step();
    exp_flags("hold_no_refire", 1, 0, 0);
    ring_again();
    exp_flags("refire", 1, 1, 0);

    // 3: snooze
    pulse(SNZ);
`ifdef ALARM_SNOOZE_EN
    exp_flags("snooze_entry", 1, 0, 1);
    ticks(299);
    exp_flags("snooze_299", 1, 0, 1);
    ticks(1);
    exp_flags("snooze_resume", 1, 1, 0);
`else
    exp_flags("snooze_ignored", 1, 1, 0);
`endif
    pulse(STP);
    exp_flags("stop_to_armed", 1, 0, 0);

    // 6a: arm_toggle beats stop
    ring_again();
    exp_flags("ring_before_toggle", 1, 1, 0);
    pulse(ARM | STP);
    exp_flags("toggle_and_stop", 0, 0, 0);

    // 5: editing onto the current time does not fire
    pulse(ARM);
    set_time(1, 2, 0, 0);
    adj_en = 1'b1;
    for (int i = 0; i < 5; i++) pulse(HRU);
    for (int i = 0; i < 30; i++) pulse(MIND);
    exp_time("alarm_1200", 1, 2, 0, 0);
    exp_flags("edit_no_fire", 1, 0, 0);
    step();
    adj_en = 1'b0;
    repeat (3) step();
    exp_flags("release_no_fire", 1, 0, 0);

    // 4: wrap-around adjust
    adj_en = 1'b1;
    for (int i = 0; i < 11; i++) pulse(HRU);
    exp_time("hr_to_2300", 2, 3, 0, 0);
    pulse(MIND);
    exp_time("alarm_2359", 2, 3, 5, 9);
    pulse(HRU | MINU);
    exp_time("wrap_up_0000", 0, 0, 0, 0);
    pulse(MIND);
    exp_time("min_dn_0059", 0, 0, 5, 9);
    pulse(HRD);
    exp_time("hr_dn_2359", 2, 3, 5, 9);
    pulse(MINU | MIND);
    exp_time("min_cancel", 2, 3, 5, 9);
    pulse(HRU | HRD | MINU);
    exp_time("hr_cancel_min_wrap", 2, 3, 0, 0);
    for (int i = 0; i < 4; i++) pulse(HRD);
    exp_time("hr_20_to_19", 1, 9, 0, 0);
    pulse(HRU);
    exp_time("hr_19_to_20", 2, 0, 0, 0);
    for (int i = 0; i < 11; i++) pulse(HRD);
    exp_time("hr_10_to_09", 0, 9, 0, 0);
    pulse(HRU);
    exp_time("hr_09_to_10", 1, 0, 0, 0);
    pulse(MIND);
    exp_time("alarm_1059", 1, 0, 5, 9);
    min_up = 1'b1;
    adj_en = 1'b0;
    step();
    min_up = 1'b0;
    exp_time("adj_gated", 1, 0, 5, 9);

    // 6b: reset while ringing / snoozing
    set_time(1, 0, 5, 8);
    step();
    set_time(1, 0, 5, 9);
    step();
    exp_flags("ring_1059", 1, 1, 0);
`ifdef ALARM_SNOOZE_EN
    pulse(SNZ);
    exp_flags("snooze_before_reset", 1, 0, 1);
`endif
    reset = 1'b1;
    step();
    exp_flags("reset_mid_alarm", 0, 0, 0);
    exp_time("reset_mid_alarm_time", 0, 0, 0, 0);
    reset = 1'b0;
    step();
    step();

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
